// File: rtl/clock_route_pkg.sv
// Purpose: shared types and defaults for the clock-route path-select sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_route_pkg;

    // Path encoding shared by the request port and the committed-path output.
    typedef enum logic [1:0] {
        PATH_OFF = 2'b00,
        PATH0    = 2'b01,
        PATH1    = 2'b10,
        PATH_ILL = 2'b11
    } route_path_e;

    typedef enum logic [1:0] {
        ST_STABLE = 2'b00,
        ST_DEAD   = 2'b01,
        ST_SETTLE = 2'b10
    } route_sel_state_e;

    localparam int ROUTE_DEAD_CYCLES_DFLT   = 4;
    localparam int ROUTE_SETTLE_CYCLES_DFLT = 2;

    function automatic int route_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_route_dwell_counter.sv
// Purpose: down-counter timing the dead and settle phases of a path switch.
// Latency: load takes effect at the next edge; zero_o reflects the registered count.
// Backpressure: none; counts down to 0 and holds there until reloaded.
//
// Ports: clock, reset (sync, active-high), load_i (load strobe),
//        load_val_i (count to load), zero_o (count is 0).
module clock_route_dwell_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clock_route_path_sel_ctrl.sv
// Purpose: break-before-make sequencer for the two clock-route gate enables.
// Latency: path change done after DEAD+SETTLE cycles, to-off after DEAD, same/illegal after 1.
// Backpressure: sel_req_ready low while a switch is in flight or in reset; no request queue.
//
// Ports: clock, reset (sync, active-high); sel_req_valid/sel_req_path/sel_req_ready
//        request handshake; control_path_enable0/1 registered gate enables;
//        active_path committed path; switch_busy, switch_done, sel_err status.
module clock_route_path_sel_ctrl
    import clock_route_pkg::*;
#(
    parameter int DEAD_CYCLES   = ROUTE_DEAD_CYCLES_DFLT,
    parameter int SETTLE_CYCLES = ROUTE_SETTLE_CYCLES_DFLT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sel_req_valid,
    input  logic [1:0] sel_req_path,
    output logic       sel_req_ready,
    output logic       control_path_enable0,
    output logic       control_path_enable1,
    output logic [1:0] active_path,
    output logic       switch_busy,
    output logic       switch_done,
    output logic       sel_err
);

    localparam int CNT_W = $clog2(route_max(DEAD_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    route_sel_state_e state_q, state_d;
    route_path_e      tgt_q, tgt_d;
    route_path_e      act_q, act_d;
    route_path_e      req_path;
    logic             en0_q, en0_d;
    logic             en1_q, en1_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             done_pend_q, done_pend_d;
    logic             err_pend_q, err_pend_d;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    assign req_path      = route_path_e'(sel_req_path);
    assign sel_req_ready = (state_q == ST_STABLE) && !reset;
    assign accept        = sel_req_valid && sel_req_ready;

    clock_route_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        act_d        = act_q;
        // Same-target and illegal requests report one cycle after they are
        // accepted, so their pulses pass through a pending stage first.
        done_d       = done_pend_q;
        err_d        = err_pend_q;
        done_pend_d  = 1'b0;
        err_pend_d   = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = DEAD_LOAD;

        case (state_q)
            ST_STABLE: begin
                if (accept) begin
                    if (req_path == PATH_ILL) begin
                        err_pend_d = 1'b1;
                    end else if (req_path == act_q) begin
                        done_pend_d = 1'b1;
                    end else begin
                        tgt_d    = req_path;
                        act_d    = PATH_OFF;
                        cnt_load = 1'b1;
                        state_d  = ST_DEAD;
                    end
                end
            end
            ST_DEAD: begin
                if (cnt_zero) begin
                    if (tgt_q == PATH_OFF) begin
                        done_d  = 1'b1;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = SETTLE_LOAD;
                        state_d      = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    act_d   = tgt_q;
                    done_d  = 1'b1;
                    state_d = ST_STABLE;
                end
            end
            default: begin
                state_d = ST_STABLE;
            end
        endcase

        // Enables follow the next state and target only; the dead phase forces
        // both low, and a single target value can never select both gates.
        en0_d = (state_d != ST_DEAD) && (tgt_d == PATH0);
        en1_d = (state_d != ST_DEAD) && (tgt_d == PATH1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_STABLE;
            tgt_q       <= PATH_OFF;
            act_q       <= PATH_OFF;
            en0_q       <= 1'b0;
            en1_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            done_pend_q <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            act_q       <= act_d;
            en0_q       <= en0_d;
            en1_q       <= en1_d;
            done_q      <= done_d;
            err_q       <= err_d;
            done_pend_q <= done_pend_d;
            err_pend_q  <= err_pend_d;
        end
    end

    assign control_path_enable0 = en0_q;
    assign control_path_enable1 = en1_q;
    assign active_path          = act_q;
    assign switch_busy          = (state_q != ST_STABLE);
    assign switch_done          = done_q;
    assign sel_err              = err_q;

endmodule
